// File: rtl/blackjack_pkg.sv
// Shared deck constants, card record and index-to-card mapping for the BlackJack datapath.
package blackjack_pkg;

  localparam int NUM_CARDS     = 52;
  localparam int RAND_W        = 6;
  localparam int IDX_W         = 6;
  localparam int MAX_TRIES_DEF = 16;

  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
    logic [3:0] points;
  } card_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAW    = 2'd1,
    ST_DELIVER = 2'd2
  } dealer_state_e;

  // Cards are numbered suit-major: idx 0..12 is suit 0 Ace..King.
  function automatic card_t idx_to_card(input logic [IDX_W-1:0] idx);
    card_t c;
    int    i;
    i        = int'(idx);
    c.suit   = 2'(i / 13);
    c.rank   = 4'((i % 13) + 1);
    c.points = (c.rank >= 4'd10) ? 4'd10 : c.rank;
    return c;
  endfunction

endpackage

// File: rtl/card_free_finder.sv
// Lowest undealt card index from the dealt mask; purely combinational.
// found_o is low only when every card is dealt.
module card_free_finder
  import blackjack_pkg::*;
(
  input  logic [NUM_CARDS-1:0] dealt_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Scan downward so the last hit written is the lowest free index.
    for (int i = NUM_CARDS - 1; i >= 0; i--) begin
      if (!dealt_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Round-robin card draw server for player/dealer: rejection-samples rand_in against a dealt mask,
// falls back to the lowest free card after MAX_TRIES rejects; all outputs registered.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAND_W-1:0] rand_in,
  input  logic              shuffle,
  input  logic [1:0]        req,
  output logic [1:0]        grant,
  output logic              card_valid,
  output logic [3:0]        card_rank,
  output logic [1:0]        card_suit,
  output logic [3:0]        card_points,
  output logic [5:0]        cards_left,
  output logic              deck_empty,
  output logic              busy
);

  localparam int TRY_W    = $clog2(MAX_TRIES + 1);
  localparam int SAMPLE_N = 1 << RAND_W;

  dealer_state_e          state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic                   card_valid_q, card_valid_d;
  card_t                  card_q, card_d;
  logic [5:0]             cards_left_q, cards_left_d;
  logic                   deck_empty_q, deck_empty_d;
  logic                   busy_q, busy_d;
  logic [NUM_CARDS-1:0]   dealt_q, dealt_d;
  logic [TRY_W-1:0]       try_q, try_d;
  logic                   last_dealer_q, last_dealer_d;

  logic [SAMPLE_N-1:0]    dealt_pad;
  logic                   sample_hit;
  logic                   fallback;
  logic [IDX_W-1:0]       free_idx;
  logic                   free_found;
  logic                   pick_ok;
  logic [IDX_W-1:0]       pick_idx;
  logic [1:0]             win;

  card_free_finder u_free (
    .dealt_i (dealt_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  // Out-of-range samples look permanently dealt, so one lookup rejects both cases.
  assign dealt_pad  = {{(SAMPLE_N - NUM_CARDS){1'b1}}, dealt_q};
  assign sample_hit = !dealt_pad[rand_in];
  assign fallback   = (try_q == TRY_W'(MAX_TRIES));
  assign pick_ok    = fallback ? free_found : sample_hit;
  assign pick_idx   = fallback ? free_idx : IDX_W'(rand_in);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_dealer_q ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    card_valid_d  = 1'b0;
    card_d        = card_q;
    cards_left_d  = cards_left_q;
    deck_empty_d  = deck_empty_q;
    dealt_d       = dealt_q;
    try_d         = try_q;
    last_dealer_d = last_dealer_q;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          if (cards_left_q == 6'd0) begin
            deck_empty_d = 1'b1;
          end else begin
            deck_empty_d  = 1'b0;
            grant_d       = win;
            last_dealer_d = win[1];
            state_d       = ST_DRAW;
          end
        end else begin
          deck_empty_d = 1'b0;
        end
      end
      ST_DRAW: begin
        if (pick_ok) begin
          dealt_d[pick_idx] = 1'b1;
          cards_left_d      = cards_left_q - 6'd1;
          card_d            = idx_to_card(pick_idx);
          card_valid_d      = 1'b1;
          state_d           = ST_DELIVER;
        end else if (!fallback) begin
          try_d = try_q + TRY_W'(1);
        end
      end
      ST_DELIVER: begin
        grant_d = 2'b00;
        try_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase

    // A shuffle aborts any draw; a card already on the outputs still goes out this cycle.
    if (shuffle) begin
      dealt_d       = '0;
      cards_left_d  = 6'(NUM_CARDS);
      try_d         = '0;
      state_d       = ST_IDLE;
      grant_d       = 2'b00;
      card_valid_d  = 1'b0;
      card_d        = card_q;
      deck_empty_d  = 1'b0;
      last_dealer_d = last_dealer_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= 2'b00;
      card_valid_q  <= 1'b0;
      card_q        <= '0;
      cards_left_q  <= 6'(NUM_CARDS);
      deck_empty_q  <= 1'b0;
      busy_q        <= 1'b0;
      dealt_q       <= '0;
      try_q         <= '0;
      last_dealer_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      card_valid_q  <= card_valid_d;
      card_q        <= card_d;
      cards_left_q  <= cards_left_d;
      deck_empty_q  <= deck_empty_d;
      busy_q        <= busy_d;
      dealt_q       <= dealt_d;
      try_q         <= try_d;
      last_dealer_q <= last_dealer_d;
    end
  end

  assign grant       = grant_q;
  assign card_valid  = card_valid_q;
  assign card_rank   = card_q.rank;
  assign card_suit   = card_q.suit;
  assign card_points = card_q.points;
  assign cards_left  = cards_left_q;
  assign deck_empty  = deck_empty_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed plus randomized bench for card_dealer against a transaction-level deck model.
module tb_card_dealer;

  localparam int NCARDS = 52;
  localparam int MAXT   = 16;

  logic       clk;
  logic       rst_n;
  logic [5:0] rand_in;
  logic       shuffle;
  logic [1:0] req;
  logic [1:0] grant;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_points;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       busy;

  card_dealer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rand_in     (rand_in),
    .shuffle     (shuffle),
    .req         (req),
    .grant       (grant),
    .card_valid  (card_valid),
    .card_rank   (card_rank),
    .card_suit   (card_suit),
    .card_points (card_points),
    .cards_left  (cards_left),
    .deck_empty  (deck_empty),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert;
  int         n_fail;
  bit         m_dealt [NCARDS];
  int         m_left;
  bit         m_last_dealer;
  logic [5:0] rseq [$];
  int         last_rank, last_suit, last_pts, last_lat, last_grant;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NCARDS; i++) if (!m_dealt[i]) return i;
    return -1;
  endfunction

  function automatic void model_shuffle();
    for (int i = 0; i < NCARDS; i++) m_dealt[i] = 1'b0;
    m_left = NCARDS;
  endfunction

  // One full draw transaction; DRAW-cycle samples come from rseq (63 once exhausted).
  task automatic draw(input logic [1:0] r, input logic [1:0] r_after,
                      input bit drop_early, input bit shuf_at_valid, input string tag);
    int exp_g, exp_idx, exp_k, got_k, e_rank, e_suit, e_pts, s;
    exp_g   = (r == 2'b11) ? (m_last_dealer ? 1 : 2) : int'(r);
    exp_idx = -1;
    exp_k   = -1;
    for (int k = 0; k <= MAXT; k++) begin
      s = (k < rseq.size()) ? int'(rseq[k]) : 63;
      if (k == MAXT) begin
        exp_idx = lowest_free();
        exp_k   = k;
        break;
      end
      if (s < NCARDS && !m_dealt[s]) begin
        exp_idx = s;
        exp_k   = k;
        break;
      end
    end
    e_suit = exp_idx / 13;
    e_rank = exp_idx % 13 + 1;
    e_pts  = (e_rank >= 10) ? 10 : e_rank;

    req = r;
    tick();
    check({tag, "_grant_draw"}, int'(grant), exp_g);
    check({tag, "_busy_draw"}, int'(busy), 1);
    if (drop_early) req = 2'b00;
    got_k = -1;
    for (int k = 0; k < 40; k++) begin
      rand_in = (k < rseq.size()) ? rseq[k] : 6'd63;
      tick();
      if (card_valid) begin
        got_k = k;
        break;
      end
    end
    last_lat   = got_k + 2;
    last_rank  = int'(card_rank);
    last_suit  = int'(card_suit);
    last_pts   = int'(card_points);
    last_grant = int'(grant);
    check({tag, "_latency"}, last_lat, exp_k + 2);
    check({tag, "_grant_valid"}, last_grant, exp_g);
    check({tag, "_rank"}, last_rank, e_rank);
    check({tag, "_suit"}, last_suit, e_suit);
    check({tag, "_points"}, last_pts, e_pts);
    check({tag, "_left"}, int'(cards_left), m_left - 1);

    if (exp_idx >= 0) m_dealt[exp_idx] = 1'b1;
    m_left--;
    m_last_dealer = (exp_g == 2);

    req     = r_after;
    shuffle = shuf_at_valid;
    rand_in = 6'($urandom_range(0, 63));
    tick();
    shuffle = 1'b0;
    if (shuf_at_valid) model_shuffle();
    check({tag, "_valid_drop"}, int'(card_valid), 0);
    check({tag, "_grant_idle"}, int'(grant), 0);
    check({tag, "_busy_idle"}, int'(busy), 0);
    check({tag, "_left_idle"}, int'(cards_left), m_left);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    m_last_dealer = 1'b1;
    model_shuffle();
    rst_n   = 1'b0;
    rand_in = 6'd0;
    shuffle = 1'b0;
    req     = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_grant", int'(grant), 0);
    check("rst_valid", int'(card_valid), 0);
    check("rst_rank", int'(card_rank), 0);
    check("rst_suit", int'(card_suit), 0);
    check("rst_points", int'(card_points), 0);
    check("rst_left", int'(cards_left), 52);
    check("rst_empty", int'(deck_empty), 0);
    check("rst_busy", int'(busy), 0);
    tick();

    rseq = '{6'd5};
    draw(2'b01, 2'b00, 1'b0, 1'b0, "t1");
    check("t1_rank_const", last_rank, 6);
    check("t1_points_const", last_pts, 6);
    check("t1_lat_const", last_lat, 2);

    rseq = '{6'd60, 6'd60, 6'd60, 6'd12};
    draw(2'b10, 2'b00, 1'b0, 1'b0, "t2");
    check("t2_rank_const", last_rank, 13);
    check("t2_points_const", last_pts, 10);
    check("t2_lat_const", last_lat, 5);

    rseq = '{6'd5, 6'd18};
    draw(2'b01, 2'b00, 1'b0, 1'b0, "t3");
    check("t3_rank_const", last_rank, 6);
    check("t3_suit_const", last_suit, 1);

    rseq = '{6'd20};
    draw(2'b10, 2'b00, 1'b0, 1'b0, "t4pre");
    for (int n = 0; n < 4; n++) begin
      rseq = '{6'(21 + n)};
      draw(2'b11, (n == 3) ? 2'b00 : 2'b11, 1'b0, 1'b0, "rr");
      check("rr_grant_const", last_grant, (n % 2 == 0) ? 1 : 2);
    end

    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    model_shuffle();
    check("shuf_left", int'(cards_left), 52);
    rseq.delete();
    draw(2'b01, 2'b00, 1'b0, 1'b0, "stuck");
    check("stuck_rank_const", last_rank, 1);
    check("stuck_points_const", last_pts, 1);
    check("stuck_lat_const", last_lat, 18);

    while (m_left > 0) begin
      int n;
      rseq.delete();
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) rseq.push_back(6'($urandom_range(0, 63)));
      draw(2'($urandom_range(1, 3)), 2'b00, 1'($urandom_range(0, 1)), 1'b0, "rnd");
    end

    req = 2'b01;
    tick();
    check("empty_flag", int'(deck_empty), 1);
    check("empty_grant", int'(grant), 0);
    check("empty_busy", int'(busy), 0);
    check("empty_left", int'(cards_left), 0);
    tick();
    check("empty_grant2", int'(grant), 0);
    req = 2'b00;
    tick();
    check("empty_noreq", int'(deck_empty), 0);
    req = 2'b01;
    tick();
    check("empty_again", int'(deck_empty), 1);
    req     = 2'b00;
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    model_shuffle();
    check("refill_left", int'(cards_left), 52);
    check("refill_empty", int'(deck_empty), 0);

    rseq = '{6'($urandom_range(0, 51))};
    draw(2'b01, 2'b00, 1'b0, 1'b0, "after_shuf");

    req = 2'b10;
    tick();
    check("abort_grant", int'(grant), 2);
    m_last_dealer = 1'b1;
    rand_in = 6'd63;
    tick();
    rand_in = 6'd7;
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    req     = 2'b00;
    model_shuffle();
    check("abort_valid", int'(card_valid), 0);
    check("abort_left", int'(cards_left), 52);
    check("abort_busy", int'(busy), 0);
    check("abort_grant_idle", int'(grant), 0);
    tick();
    check("abort_valid2", int'(card_valid), 0);

    rseq = '{6'd30};
    draw(2'b01, 2'b00, 1'b0, 1'b1, "shuf_dlv");
    rseq = '{6'd30};
    draw(2'b10, 2'b00, 1'b0, 1'b0, "returned");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
